// File: rtl/ram_output_drain.sv
// ram_output_drain
// Read-side controller for the output RAM. On start it owns the RAM port,
// reads words 0..count-1 in order, absorbs the fixed RAM read latency in a
// credit-managed skid FIFO and presents the words as a backpressured stream
// with m_last on the final word.

`ifndef COLS
`define COLS 4
`endif
`ifndef ROWS
`define ROWS 4
`endif
`ifndef Y_BITS
`define Y_BITS 16
`endif

module ram_output_drain #(
  parameter int DEPTH      = `COLS * `ROWS,
  parameter int WIDTH      = `Y_BITS,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_ena,
  output logic [$clog2(DEPTH)-1:0]   ram_addr,
  input  logic [WIDTH-1:0]           ram_dout,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last
);

  // Widths: word counters, RAM address, FIFO pointer/occupancy, in-flight
  // count and the credit sum (occupancy + in-flight).
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(LATENCY + 1);
  localparam int SW  = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of reads currently travelling through the RAM pipeline.
  function automatic logic [IW-1:0] popcount(input logic [LATENCY-1:0] v);
    logic [IW-1:0] acc;
    acc = '0;
    for (int i = 0; i < LATENCY; i++) begin
      acc = acc + IW'(v[i]);
    end
    return acc;
  endfunction

  // Circular pointer advance for a FIFO that need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Control state
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   beats_q, beats_d;
  logic            zero_done_q, zero_done_d;

  // In-flight valid shift register, aligned with the RAM read pipeline
  logic [LATENCY-1:0] sr_q, sr_d;

  // Skid FIFO
  logic [WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]   fifo_cnt_q, fifo_cnt_d;

  // Decoded control signals
  logic [CW-1:0] count_clamped_s;
  logic          busy_s;
  logic          m_valid_s;
  logic          pop_s;
  logic [IW-1:0] inflight_s;
  logic          credit_ok_s;
  logic          issue_s;
  logic          push_s;
  logic          last_beat_s;
  logic          final_hs_s;

  // Decode handshakes, credits and the end-of-drain condition from the flops.
  always_comb begin
    count_clamped_s = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
    busy_s          = (state_q != ST_IDLE);
    m_valid_s       = (fifo_cnt_q != '0);
    pop_s           = m_valid_s && m_ready;
    inflight_s      = popcount(sr_q);
    // A word exiting the RAM this cycle is still counted as in flight, so the
    // credit check is conservative and a push can never hit a full FIFO.
    credit_ok_s     = (SW'(fifo_cnt_q) + SW'(inflight_s)) < SW'(FIFO_DEPTH);
    issue_s         = (state_q == ST_ISSUE) && credit_ok_s;
    push_s          = busy_s && sr_q[LATENCY-1];
    last_beat_s     = m_valid_s && (beats_q == cnt_q - CW'(1));
    final_hs_s      = (state_q == ST_DRAIN) && pop_s && last_beat_s &&
                      (fifo_cnt_q == FCW'(1)) && (inflight_s == '0);
  end

  // Next-state logic for the IDLE/ISSUE/DRAIN sequencer and its counters.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issue_cnt_d = issue_cnt_q;
    beats_d     = beats_q;
    zero_done_d = 1'b0;

    if (pop_s) begin
      beats_d = beats_q + CW'(1);
    end else begin
      beats_d = beats_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_clamped_s != '0) begin
            cnt_d       = count_clamped_s;
            issue_cnt_d = '0;
            beats_d     = '0;
            state_d     = ST_ISSUE;
          end else begin
            // Empty drain: acknowledge with done only, never take the port.
            zero_done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
          if (issue_cnt_q == cnt_q - CW'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
      end
      ST_DRAIN: begin
        if (final_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shift the in-flight markers whenever the RAM pipeline advances.
  always_comb begin
    sr_d = sr_q;
    if (busy_s) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        sr_d[i] = sr_q[i-1];
      end
      sr_d[0] = issue_s;
    end else begin
      sr_d = sr_q;
    end
  end

  // Skid FIFO bookkeeping: capture RAM data as it arrives, release on handshake.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;

    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = ram_dout;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State, counters, in-flight markers and FIFO storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      issue_cnt_q <= '0;
      beats_q     <= '0;
      zero_done_q <= 1'b0;
      sr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      issue_cnt_q <= issue_cnt_d;
      beats_q     <= beats_d;
      zero_done_q <= zero_done_d;
      sr_q        <= sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= fifo_mem_d[i];
      end
    end
  end

  // Drive the ports from the registered state.
  always_comb begin
    busy    = busy_s;
    ram_ena = busy_s;
    if (state_q == ST_ISSUE) begin
      ram_addr = issue_cnt_q[AW-1:0];
    end else begin
      ram_addr = '0;
    end
    done    = zero_done_q || final_hs_s;
    m_valid = m_valid_s;
    m_data  = fifo_mem_q[rd_ptr_q];
    m_last  = last_beat_s;
  end

endmodule

// File: tb/tb_ram_output_drain.sv
// Self-checking bench for ram_output_drain: a latency-accurate RAM model, a
// queue-based reference of the expected stream and one compare process that
// checks every cycle, plus literal timing expectations for the key scenarios.

module tb_ram_output_drain;

  localparam int DEPTH      = 16;
  localparam int WIDTH      = 16;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int AW         = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [CW-1:0]    count;
  logic             busy, done, ram_ena, m_valid, m_ready, m_last;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout, m_data;

  ram_output_drain #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .count(count), .busy(busy),
    .done(done), .ram_ena(ram_ena), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with a fixed read latency counted in enabled cycles
  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] pipe [LATENCY];
  always @(posedge clk) begin
    if (ram_ena) begin
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign ram_dout = pipe[LATENCY-1];

  // Bookkeeping
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];
  bit               mdl_busy  = 1'b0;
  bit               pend_zero = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  int               t0 = 0;

  // Logs of the current run, relative to the start cycle
  int               beat_rel[$];
  logic [WIDTH-1:0] beat_dat[$];
  bit               beat_last[$];
  int               done_rel[$];
  int               busy_hi_rel = -1;
  int               busy_lo_rel = -1;

  // m_ready driver
  bit ready_mode = 1'b0;
  bit ready_val  = 1'b0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Compare process: sample DUT outputs mid-cycle against the reference model
  always @(negedge clk) begin
    int  rel;
    bit  nb;
    bit  exp_done;
    int  n;
    rel = cyc - t0;
    if (!rstn) begin
      check("rst_busy",    busy,     1'b0);
      check("rst_done",    done,     1'b0);
      check("rst_ram_ena", ram_ena,  1'b0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_m_valid", m_valid,  1'b0);
      check("rst_m_last",  m_last,   1'b0);
      check("rst_m_data",  m_data,   '0);
      exp_q.delete();
      mdl_busy   = 1'b0;
      pend_zero  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      nb        = mdl_busy;
      exp_done  = pend_zero;
      pend_zero = 1'b0;
      check("busy", busy, mdl_busy);
      check("ram_ena", ram_ena, mdl_busy);
      check("m_last", m_last, m_valid && (exp_q.size() == 1));
      if (exp_q.size() == 0) check("m_valid_idle", m_valid, 1'b0);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready && exp_q.size() != 0) begin
        check("m_data", m_data, exp_q[0]);
        beat_rel.push_back(rel);
        beat_dat.push_back(m_data);
        beat_last.push_back(m_last);
        if (exp_q.size() == 1) begin
          exp_done = 1'b1;
          nb       = 1'b0;
        end
        void'(exp_q.pop_front());
      end
      check("done", done, exp_done);
      if (done) done_rel.push_back(rel);
      if (busy && busy_hi_rel < 0) busy_hi_rel = rel;
      if (!busy && busy_hi_rel >= 0 && busy_lo_rel < 0) busy_lo_rel = rel;
      if (start && !mdl_busy) begin
        n = (int'(count) > DEPTH) ? DEPTH : int'(count);
        if (n == 0) begin
          pend_zero = 1'b1;
        end else begin
          for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
          nb = 1'b1;
        end
      end
      mdl_busy   = nb;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Stimulus helpers; all start and end at posedge + #1
  task automatic launch(input int n);
    beat_rel.delete(); beat_dat.delete(); beat_last.delete(); done_rel.delete();
    busy_hi_rel = -1;
    busy_lo_rel = -1;
    t0    = cyc;
    start = 1'b1;
    count = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse(input int n);
    start = 1'b1;
    count = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy === 1'b1 || mdl_busy || exp_q.size() != 0 || pend_zero) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (n < budget), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic set_ready(input bit mode, input bit val);
    ready_mode = mode;
    ready_val  = val;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full drain: addr+1 contents, 8 words, ready held high
    set_ready(1'b0, 1'b1);
    launch(8);
    wait_idle(100);
    check("full_beats", beat_rel.size(), 8);
    for (int k = 0; k < beat_rel.size(); k++) begin
      check("full_cycle", beat_rel[k], 4 + k);
      check("full_data", beat_dat[k], k + 1);
      check("full_last", beat_last[k], (k == 7));
    end
    check("full_done_count", done_rel.size(), 1);
    if (done_rel.size() > 0) check("full_done_cycle", done_rel[0], 11);
    check("full_busy_rise", busy_hi_rel, 1);
    check("full_busy_fall", busy_lo_rel, 12);

    // Random backpressure over the whole RAM
    fill_random();
    set_ready(1'b1, 1'b0);
    launch(DEPTH);
    wait_idle(400);
    check("rand_beats", beat_rel.size(), DEPTH);

    // Long stall: credits cap the issue at FIFO_DEPTH reads
    fill_random();
    set_ready(1'b0, 1'b0);
    launch(8);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("stall_issue_addr", ram_addr, FIFO_DEPTH);
    check("stall_m_valid", m_valid, 1'b1);
    check("stall_no_beats", beat_rel.size(), 0);
    @(posedge clk); #1;
    ready_val = 1'b1;
    wait_idle(100);
    check("stall_beats", beat_rel.size(), 8);
    for (int k = 1; k < beat_rel.size(); k++) check("stall_gap", beat_rel[k] - beat_rel[k-1], 1);

    // count = 0: done one cycle later, busy never rises
    launch(0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_done_count", done_rel.size(), 1);
    if (done_rel.size() > 0) check("zero_done_cycle", done_rel[0], 1);
    check("zero_busy_never", busy_hi_rel, -1);

    // count = 1: a single beat flagged last
    fill_random();
    launch(1);
    wait_idle(50);
    check("one_beats", beat_rel.size(), 1);
    if (beat_rel.size() > 0) begin
      check("one_last", beat_last[0], 1'b1);
      check("one_cycle", beat_rel[0], 4);
    end

    // count above DEPTH is clamped
    launch(DEPTH + 5);
    wait_idle(100);
    check("clamp_beats", beat_rel.size(), DEPTH);
    if (done_rel.size() > 0) check("clamp_done_cycle", done_rel[0], DEPTH + 1 + LATENCY);

    // start while busy (mid-drain and in the done cycle) is ignored;
    // the cycle after done it is accepted
    launch(6);
    repeat (2) @(posedge clk);
    #1;
    pulse(3);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    count = CW'(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100);
    check("sb_beats", beat_rel.size(), 8);
    check("sb_done_count", done_rel.size(), 2);
    if (done_rel.size() == 2) begin
      check("sb_done_first", done_rel[0], 9);
      check("sb_done_second", done_rel[1], 15);
    end

    // Reset at the third beat, then a fresh 4-word drain
    fill_random();
    launch(8);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rst_beats_before", beat_rel.size(), 2);
    check("rst_no_done", done_rel.size(), 0);
    @(posedge clk); #1;
    launch(4);
    wait_idle(100);
    check("post_rst_beats", beat_rel.size(), 4);
    for (int k = 0; k < beat_rel.size(); k++) check("post_rst_data", beat_dat[k], mem[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
